// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo
//
// Decimating sink for an upstream FIR stage. Accepted samples first pass a
// warm-up gate that throws away the first WARMUP samples after reset while the
// filter pipeline fills. A phase counter then keeps one sample out of every
// DECIM. Each kept sample is pushed unchanged into a small FIFO that the
// consumer drains with a valid/ready handshake.
//
// Parameters
//   DECIM   decimation factor (1..16)
//   WARMUP  accepted samples discarded after reset (0..255)
//   DEPTH   FIFO entries, power of two (2..64)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   x_in        signed 10-bit sample from the FIR stage
//   in_en       x_in is valid this cycle
//   dout        FIFO head sample (0 while empty)
//   dout_valid  FIFO is non-empty
//   dout_ready  consumer takes dout this cycle
//   level       FIFO occupancy, 0..DEPTH
//   overflow    sticky flag: a kept sample was dropped on a full FIFO
//   clr_ovf     synchronous clear of overflow (a new overflow wins)

module fir_decim_fifo #(
  parameter int DECIM  = 4,
  parameter int WARMUP = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [9:0]        x_in,
  input  logic                     in_en,
  output logic signed [9:0]        dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [7:0]  WARM_LAST  = 8'(WARMUP);
  localparam logic [3:0]  PHASE_LAST = 4'(DECIM - 1);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [7:0]        warm_cnt;
  logic              warm_done;
  logic [3:0]        phase;
  logic              keep;

  logic signed [9:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic              ovf_event;

  // The warm-up counter saturates at WARMUP, so WARMUP=0 means "done" from
  // the first cycle out of reset.
  assign warm_done = (warm_cnt == WARM_LAST);
  assign keep      = in_en && warm_done && (phase == 4'd0);

  // Warm-up and phase counters only move on accepted samples and never look
  // at the FIFO, so a sample dropped on overflow still uses its phase slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt <= 8'd0;
      phase    <= 4'd0;
    end else if (in_en) begin
      if (!warm_done) begin
        warm_cnt <= warm_cnt + 8'd1;
      end else if (phase == PHASE_LAST) begin
        phase <= 4'd0;
      end else begin
        phase <= phase + 4'd1;
      end
    end
  end

  // When full, a push is only taken if the head leaves on the same edge. In
  // that case wr_ptr equals rd_ptr, so the new sample lands in the slot being
  // vacated and becomes the new tail.
  assign full      = (level == FULL_LEVEL);
  assign pop       = dout_valid && dout_ready;
  assign wr_en     = keep && (!full || pop);
  assign ovf_event = keep && full && !pop;

  // Storage is not reset; dout is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= x_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow; a fresh overflow takes priority over a clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (ovf_event) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign dout_valid = (level != '0);
  assign dout       = dout_valid ? mem[rd_ptr] : 10'sd0;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// tb_fir_decim_fifo
//
// Self-checking bench for fir_decim_fifo. The main instance uses default
// parameters and is compared every cycle against a reference model built
// from the keep rule (sample index n is kept when n >= WARMUP and
// (n - WARMUP) is a multiple of DECIM) plus a bounded queue. A second
// instance with DECIM=1, WARMUP=0, DEPTH=2 covers signed passthrough,
// clear-versus-set on overflow and full push+pop on a tiny FIFO.

module tb_fir_decim_fifo;

  localparam int DECIM  = 4;
  localparam int WARMUP = 8;
  localparam int DEPTH  = 8;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;

  logic signed [9:0] x_in;
  logic              in_en;
  logic signed [9:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              clr_ovf;

  logic signed [9:0] d1_x;
  logic              d1_en;
  logic signed [9:0] d1_dout;
  logic              d1_valid;
  logic              d1_ready;
  logic [1:0]        d1_level;
  logic              d1_ovf;
  logic              d1_clr;

  int checks = 0;
  int errors = 0;

  int acc;
  bit m_ovf;
  int q[$];
  int got[$];

  always #5 clk = ~clk;

  fir_decim_fifo #(.DECIM(DECIM), .WARMUP(WARMUP), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .x_in       (x_in),
    .in_en      (in_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  fir_decim_fifo #(.DECIM(1), .WARMUP(0), .DEPTH(2)) dut_d1 (
    .clk        (clk),
    .rst        (rst),
    .x_in       (d1_x),
    .in_en      (d1_en),
    .dout       (d1_dout),
    .dout_valid (d1_valid),
    .dout_ready (d1_ready),
    .level      (d1_level),
    .overflow   (d1_ovf),
    .clr_ovf    (d1_clr)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Keep rule stated directly in terms of the accepted-sample index.
  function automatic bit keepSample(input int n);
    return (n >= WARMUP) && (((n - WARMUP) % DECIM) == 0);
  endfunction

  task automatic modelReset();
    acc   = 0;
    m_ovf = 1'b0;
    q.delete();
  endtask

  // Drive one cycle of inputs on the main instance. Outputs are compared
  // against the model state before the edge, then the model is advanced with
  // the same inputs and the task returns 1 time unit after the edge.
  task automatic applyStimulus(input bit en, input int x, input bit rdy, input bit clr);
    bit pop;
    bit push;
    bit ovf_ev;
    int sz;
    in_en      = en;
    x_in       = 10'(x);
    dout_ready = rdy;
    clr_ovf    = clr;
    sz = q.size();
    checkOutput("dout_valid", int'(dout_valid), int'(sz != 0));
    checkOutput("level", int'(level), sz);
    checkOutput("overflow", int'(overflow), int'(m_ovf));
    checkOutput("dout", int'(dout), (sz != 0) ? q[0] : 0);
    pop    = (sz != 0) && rdy;
    push   = en && keepSample(acc);
    ovf_ev = 1'b0;
    if (pop) begin
      got.push_back(int'(dout));
      void'(q.pop_front());
    end
    if (push) begin
      if (sz < DEPTH || pop) q.push_back(x);
      else ovf_ev = 1'b1;
    end
    if (en) acc++;
    m_ovf = ovf_ev || (m_ovf && !clr);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges: outputs must clear immediately.
  task automatic doReset();
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_level", int'(level), 0);
    checkOutput("rst_valid", int'(dout_valid), 0);
    checkOutput("rst_ovf", int'(overflow), 0);
    checkOutput("rst_dout", int'(dout), 0);
    modelReset();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // One edge on the DECIM=1 instance while the main instance idles.
  task automatic d1Edge(input bit en, input int x, input bit rdy, input bit clr);
    d1_en    = en;
    d1_x     = 10'(x);
    d1_ready = rdy;
    d1_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  // Main sequence: reset, DECIM=1 directed tests, then the decimating
  // scenarios and a randomized soak against the model.
  initial begin
    int n;
    bit en;
    bit rdy;
    int x;

    rst = 1'b1;
    x_in = '0; in_en = 1'b0; dout_ready = 1'b0; clr_ovf = 1'b0;
    d1_x = '0; d1_en = 1'b0; d1_ready = 1'b0; d1_clr = 1'b0;
    modelReset();
    #1;
    checkOutput("init_level", int'(level), 0);
    checkOutput("init_valid", int'(dout_valid), 0);
    checkOutput("init_ovf", int'(overflow), 0);
    checkOutput("init_dout", int'(dout), 0);
    checkOutput("init_d1_level", int'(d1_level), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Signed extremes, one-edge latency, overflow with clear on same edge.
    d1Edge(1, -512, 0, 0);
    checkOutput("d1_latency_valid", int'(d1_valid), 1);
    checkOutput("d1_neg_dout", int'(d1_dout), -512);
    d1Edge(1, 511, 0, 0);
    checkOutput("d1_level2", int'(d1_level), 2);
    checkOutput("d1_hold_dout", int'(d1_dout), -512);
    d1Edge(0, 0, 1, 0);
    checkOutput("d1_pos_dout", int'(d1_dout), 511);
    d1Edge(0, 0, 1, 0);
    checkOutput("d1_empty_valid", int'(d1_valid), 0);
    checkOutput("d1_empty_dout", int'(d1_dout), 0);
    d1Edge(1, 100, 0, 0);
    d1Edge(1, -100, 0, 0);
    d1Edge(1, 7, 0, 1);
    checkOutput("d1_ovf_set_wins", int'(d1_ovf), 1);
    checkOutput("d1_ovf_level", int'(d1_level), 2);
    checkOutput("d1_ovf_head", int'(d1_dout), 100);
    d1Edge(0, 0, 0, 1);
    checkOutput("d1_ovf_cleared", int'(d1_ovf), 0);
    d1Edge(1, 55, 1, 0);
    checkOutput("d1_full_pushpop_level", int'(d1_level), 2);
    checkOutput("d1_full_pushpop_ovf", int'(d1_ovf), 0);
    checkOutput("d1_full_pushpop_head", int'(d1_dout), -100);
    d1Edge(0, 0, 1, 0);
    checkOutput("d1_tail_dout", int'(d1_dout), 55);
    d1Edge(0, 0, 1, 0);
    checkOutput("d1_drained", int'(d1_valid), 0);

    // Continuous ramp with a free-running consumer.
    got.delete();
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, i, 1'b1, 1'b0);
    checkOutput("ramp_count", got.size(), 8);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) checkOutput("ramp_value", got[k], 8 + 4 * k);

    // Gapped input: the same outputs as the continuous ramp.
    doReset();
    got.delete();
    n = 0;
    for (int i = 0; i < 80; i++) begin
      en = (i % 2) == 0;
      applyStimulus(en, n, 1'b1, 1'b0);
      if (en) n++;
    end
    checkOutput("gap_count", got.size(), 8);
    for (int k = 0; k < 4; k++)
      if (k < got.size()) checkOutput("gap_value", got[k], 8 + 4 * k);

    // Fill with a stalled consumer until overflow.
    doReset();
    for (int i = 0; i < 48; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
    checkOutput("fill_level", int'(level), 8);
    checkOutput("fill_ovf", int'(overflow), 1);
    got.delete();
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    if (got.size() > 0) checkOutput("fill_first_pop", got[0], 8);
    else checkOutput("fill_first_pop_count", got.size(), 1);

    // Full FIFO with push and pop on the same edge.
    doReset();
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
    checkOutput("full_level", int'(level), 8);
    checkOutput("full_ovf", int'(overflow), 0);
    got.delete();
    applyStimulus(1'b1, 40, 1'b1, 1'b0);
    checkOutput("pushpop_level", int'(level), 8);
    checkOutput("pushpop_ovf", int'(overflow), 0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkOutput("pushpop_count", got.size(), 9);
    if (got.size() == 9) begin
      checkOutput("pushpop_first", got[0], 8);
      checkOutput("pushpop_last", got[8], 40);
    end

    // Reset mid-stream with five entries, then warm-up restarts.
    doReset();
    for (int i = 0; i < 25; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
    checkOutput("pre_rst_level", int'(level), 5);
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 100 + i, 1'b1, 1'b0);
    checkOutput("rewarm_level", int'(level), 0);
    applyStimulus(1'b1, 200, 1'b0, 1'b0);
    checkOutput("rewarm_first_level", int'(level), 1);
    checkOutput("rewarm_first_dout", int'(dout), 200);

    // Randomized soak with alternating consumer pressure and rare clears.
    doReset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) doReset();
      en  = $urandom_range(0, 3) != 0;
      x   = int'($urandom_range(0, 1023)) - 512;
      if (((i / 100) % 2) == 0) rdy = $urandom_range(0, 9) < 3;
      else rdy = $urandom_range(0, 9) < 7;
      applyStimulus(en, x, rdy, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
